fc_rx_decoder: RTL

Front-end receiver for the encoded fast-control stream produced on the PF link. Each clk_bx cycle it takes one 16-bit word carrying two Hamming(8,4) codewords. It corrects single-bit errors, flags double-bit errors, and regenerates the command strobes (BCR, L1A, link reset, buffer clear, calib). It also runs a local bunch-crossing counter with a BCR lock state machine, used to timestamp L1As on the receiving side.

---
 rtl/fc_rx_decoder.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fc_rx_decoder.sv
// -----------------------------------------------------------------------------
// fc_rx_decoder
//
// Receive front-end for the encoded fast-control stream on the PF link.
// Each clk_bx cycle carries one 16-bit word made of two Hamming(8,4) SEC-DED
// codewords. The high codeword holds command bits [7:4] and the low codeword
// holds bits [3:0]. The block corrects single-bit errors and flags double-bit
// errors. It regenerates the command strobes and runs a local bunch-crossing
// counter. A BCR lock FSM tracks that counter, and the counter value is used
// to timestamp L1As.
//
// Pipeline: stage 1 registers the raw word. Stage 2 decodes it and registers
// every output, so a word presented in cycle n appears on the outputs in
// cycle n+2.
//
// Parameters:
//   LOCK_COUNT     consecutive aligned BCRs needed in CHECK before LOCKED (1..15)
//
// Ports:
//   clk_bx         in   1   bunch-crossing clock, rising edge
//   reset_n        in   1   asynchronous active-low reset
//   fc_stream_enc  in  16   [7:0] codeword of cmd[3:0], [15:8] codeword of cmd[7:4]
//   orb_length     in  12   orbit length in bx (0 -> natural 4096 wrap)
//   bcr            out  1   bunch-counter-reset strobe (cmd bit 0)
//   l1a            out  1   L1A strobe (cmd bit 1)
//   link_reset     out  1   link reset strobe (cmd bit 2)
//   buffer_clear   out  1   buffer clear strobe (cmd bit 3)
//   calib_pulse    out  1   calib level (cmd bit 5)
//   bxid           out 12   local bunch-crossing counter
//   l1a_bxid       out 12   bxid captured on the last L1A
//   locked         out  1   lock FSM is in LOCKED (registered from state)
//   sec_err        out  1   at least one codeword corrected this cycle
//   ded_err        out  1   at least one codeword uncorrectable this cycle
//
// Optional feature, enabled by defining FC_RX_ERRCNT_EN:
//   err_clear      in   1   synchronous clear of all counters, wins over increment
//   sec_count      out 16   saturating count of sec_err cycles
//   ded_count      out 16   saturating count of ded_err cycles
//   unlock_count   out  8   saturating count of LOCKED -> UNLOCKED transitions
// -----------------------------------------------------------------------------
module fc_rx_decoder #(
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clk_bx,
    input  logic        reset_n,
    input  logic [15:0] fc_stream_enc,
    input  logic [11:0] orb_length,
`ifdef FC_RX_ERRCNT_EN
    input  logic        err_clear,
    output logic [15:0] sec_count,
    output logic [15:0] ded_count,
    output logic [7:0]  unlock_count,
`endif
    output logic        bcr,
    output logic        l1a,
    output logic        link_reset,
    output logic        buffer_clear,
    output logic        calib_pulse,
    output logic [11:0] bxid,
    output logic [11:0] l1a_bxid,
    output logic        locked,
    output logic        sec_err,
    output logic        ded_err
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Result of decoding one Hamming(8,4) codeword.
    typedef struct packed {
        logic [3:0] data;
        logic       sec;
        logic       ded;
    } hdec_t;

    // Codeword layout: [0]=d0^d1^d3, [1]=d0^d2^d3, [2]=d0, [3]=d1^d2^d3,
    // [4]=d1, [5]=d2, [6]=d3, [7]=even parity over [6:0].
    // The syndrome is the 1-based position of a single flipped bit in [6:0].
    // The overall parity tells a single error (odd) from a double error (even).
    function automatic hdec_t hamming84_dec(input logic [7:0] c);
        logic [2:0] s;
        logic       p;
        logic [7:0] cc;
        hdec_t      r;
        s  = {c[3] ^ c[4] ^ c[5] ^ c[6],
              c[1] ^ c[2] ^ c[5] ^ c[6],
              c[0] ^ c[2] ^ c[4] ^ c[6]};
        p  = ^c;
        cc = c;
        r  = '0;
        if (s != 3'd0 && p) begin
            cc[s - 3'd1] = ~cc[s - 3'd1];
            r.sec = 1'b1;
        end else if (s == 3'd0 && p) begin
            // Only the overall parity bit flipped; the data bits are intact.
            r.sec = 1'b1;
        end else if (s != 3'd0 && !p) begin
            r.ded = 1'b1;
        end
        // An uncorrectable codeword must never fire a command.
        r.data = r.ded ? 4'b0000 : {cc[6], cc[5], cc[4], cc[2]};
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Stage 1: raw input register
    // -------------------------------------------------------------------------
    logic [15:0] fc_q;

    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every register samples values from before the clock edge.
    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_stream_enc;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 combinational decode
    // -------------------------------------------------------------------------
    hdec_t       dec_lo;
    hdec_t       dec_hi;
    logic [7:0]  cmd;
    logic        sec_any;
    logic        ded_any;

    assign dec_lo  = hamming84_dec(fc_q[7:0]);
    assign dec_hi  = hamming84_dec(fc_q[15:8]);
    assign cmd     = {dec_hi.data, dec_lo.data};
    assign sec_any = dec_lo.sec | dec_hi.sec;
    assign ded_any = dec_lo.ded | dec_hi.ded;

    // Command bits 4, 6 and 7 are defined on the link but unused here.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd[7:6], cmd[4]};

    // -------------------------------------------------------------------------
    // Bunch-crossing counter and alignment checks
    // -------------------------------------------------------------------------
    // Subtraction is modulo 2^12, so orb_length=0 makes the last bx 4095.
    logic [11:0] last_bx;
    logic        at_last;
    logic [11:0] bxid_next;
    logic        bcr_aligned;
    logic        bcr_misaligned;
    logic        bcr_missing;

    assign last_bx   = orb_length - 12'd1;
    assign at_last   = (bxid == last_bx);
    assign bxid_next = (cmd[0] || at_last) ? 12'd0 : bxid + 12'd1;

    // A DED on the low codeword already forced cmd[0] to 0. It also suppresses
    // the missing check, so the counter flywheels through a corrupted BCR slot.
    assign bcr_aligned    = cmd[0] && at_last;
    assign bcr_misaligned = cmd[0] && !at_last;
    assign bcr_missing    = !cmd[0] && at_last && !dec_lo.ded;

    // -------------------------------------------------------------------------
    // Lock FSM
    // -------------------------------------------------------------------------
    lock_state_t state;
    lock_state_t state_next;
    logic [3:0]  good_cnt;
    logic [3:0]  good_next;

    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_UNLOCKED;
            good_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        unique case (state)
            ST_UNLOCKED: begin
                if (cmd[0]) begin
                    state_next = ST_CHECK;
                    good_next  = 4'd0;
                end
            end
            ST_CHECK: begin
                if (bcr_misaligned || bcr_missing) begin
                    state_next = ST_UNLOCKED;
                    good_next  = 4'd0;
                end else if (bcr_aligned) begin
                    good_next = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == LOCK_TARGET) begin
                        state_next = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (bcr_misaligned || bcr_missing) begin
                    state_next = ST_UNLOCKED;
                    good_next  = 4'd0;
                end
            end
            default: begin
                state_next = ST_UNLOCKED;
                good_next  = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Stage 2 output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            bcr          <= 1'b0;
            l1a          <= 1'b0;
            link_reset   <= 1'b0;
            buffer_clear <= 1'b0;
            calib_pulse  <= 1'b0;
            sec_err      <= 1'b0;
            ded_err      <= 1'b0;
            bxid         <= 12'd0;
            l1a_bxid     <= 12'd0;
            locked       <= 1'b0;
        end else begin
            bcr          <= cmd[0];
            l1a          <= cmd[1];
            link_reset   <= cmd[2];
            buffer_clear <= cmd[3];
            calib_pulse  <= cmd[5];
            sec_err      <= sec_any;
            ded_err      <= ded_any;
            bxid         <= bxid_next;
            // Capture the value bxid takes in this same output cycle, so that
            // BCR+L1A together timestamp the L1A as bx 0.
            if (cmd[1]) begin
                l1a_bxid <= bxid_next;
            end
            locked       <= (state == ST_LOCKED);
        end
    end

    // -------------------------------------------------------------------------
    // Optional error counters
    // -------------------------------------------------------------------------
`ifdef FC_RX_ERRCNT_EN
    logic unlock_now;
    assign unlock_now = (state == ST_LOCKED) && (state_next == ST_UNLOCKED);

    // The counters step on the same edge that raises sec_err/ded_err.
    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            sec_count    <= 16'd0;
            ded_count    <= 16'd0;
            unlock_count <= 8'd0;
        end else if (err_clear) begin
            sec_count    <= 16'd0;
            ded_count    <= 16'd0;
            unlock_count <= 8'd0;
        end else begin
            if (sec_any && sec_count != 16'hFFFF) begin
                sec_count <= sec_count + 16'd1;
            end
            if (ded_any && ded_count != 16'hFFFF) begin
                ded_count <= ded_count + 16'd1;
            end
            if (unlock_now && unlock_count != 8'hFF) begin
                unlock_count <= unlock_count + 8'd1;
            end
        end
    end
`else
    // Counters are not built; errors are reported only as sec_err/ded_err.
`endif

endmodule
